// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared seven-segment constants and the active-low hex glyph table.
package seven_seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Entry n is the gfedcba pattern for hex value n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic int dwell_len(input int bright_w);
    return 1 << bright_w;
  endfunction
endpackage

// File: rtl/hex_to_seven_seg.sv
// hex_to_seven_seg: combinational 4-bit value to active-low seven-segment pattern.
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[value];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed common-anode display scanner with
// per-digit enable, PWM brightness, leading-zero suppression and scan enable.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 2
) (
  input  logic                  div_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int IW    = $clog2(DIGITS);
  localparam int DWELL = dwell_len(BRIGHT_W);
  logic [BRIGHT_W-1:0] dwell_cnt;
  logic [IW-1:0]       idx;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   sup;
  logic                chain, start, wrap, lit;
  logic [6:0]          dec, hold_seg, cur_seg;
  logic                hold_dp, hold_sup, cur_dp, cur_sup;
  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    assign nib[g] = digits[4*g +: 4];
  end
  // A digit is suppressed when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    chain = lz_en;
    sup   = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      chain  = chain & (nib[i] == 4'h0);
      sup[i] = chain;
    end
  end
  hex_to_seven_seg u_dec (.value(nib[idx]), .seg(dec));
  // Slot content is taken live at slot start and held for the rest of the slot.
  always_comb begin
    start   = dwell_cnt == '0;
    wrap    = dwell_cnt == BRIGHT_W'(DWELL - 1);
    cur_seg = start ? dec : hold_seg;
    cur_dp  = start ? dp_in[idx] : hold_dp;
    cur_sup = start ? sup[idx] : hold_sup;
    lit     = enable & digit_en[idx] & (dwell_cnt < brightness) & ~cur_sup;
  end
  always_ff @(posedge div_clock or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
      idx       <= '0;
      hold_seg  <= SEG_BLANK;
      hold_dp   <= 1'b0;
      hold_sup  <= 1'b0;
      anode     <= '1;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      if (enable) begin
        dwell_cnt <= wrap ? '0 : dwell_cnt + 1'b1;
        if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      end
      if (start) begin
        hold_seg <= dec;
        hold_dp  <= dp_in[idx];
        hold_sup <= sup[idx];
      end
      anode <= lit ? ~(DIGITS'(1) << idx) : '1;
      seg   <= lit ? cur_seg : SEG_BLANK;
      dp    <= lit ? ~cur_dp : 1'b1;
    end
  end
endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Parametrised successor to the 4-digit anode scanner.
- Time-multiplexes DIGITS common-anode seven-segment digits from one divided clock.
- Generates the one-hot active-low anode, plus hex-decoded active-low cathodes and decimal point for the lit digit.
- Adds per-digit enable, PWM brightness with an anti-ghost blank tick, leading-zero suppression and a scan enable.
- Sits between the display-value registers and the board pins.

Parameters:
- DIGITS, 4, number of digits scanned (2..8); anode index 0 = rightmost.
- BRIGHT_W, 2, brightness width; slot length DWELL = 2**BRIGHT_W div_clock cycles.

Ports:
- div_clock  input  1  divided scan clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable; low freezes scan and blanks outputs.
- digits  input  4*DIGITS  packed hex values; digit i at [4i+3:4i].
- digit_en  input  DIGITS  per-digit enable; 0 keeps that anode off.
- dp_in  input  DIGITS  decimal point request per digit, active-high.
- lz_en  input  1  leading-zero suppression enable.
- brightness  input  BRIGHT_W  on-ticks per slot; 0 = dark.
- anode  output  DIGITS  active-low one-hot digit select.
- seg  output  7  active-low cathodes, seg[0]=a .. seg[6]=g.
- dp  output  1  active-low decimal point.

Behaviour:
- State:
  - dwell_cnt counts 0..DWELL-1.
  - idx counts 0..DIGITS-1.
- Reset (reset=0, async):
  - dwell_cnt=0, idx=0.
  - anode = all 1s, seg = 7'h7F, dp = 1.
  - Takes effect immediately regardless of clock; a reset mid-scan returns to digit 0 slot start.
- Advance, per edge with enable=1:
  - dwell_cnt increments.
  - At DWELL-1, dwell_cnt wraps to 0 and idx increments.
  - At idx = DIGITS-1, idx wraps to 0.
  - For non-power-of-2 DIGITS, idx never takes values >= DIGITS.
- enable=0:
  - dwell_cnt and idx hold.
  - Outputs go to the blank state (all 1s) on the next edge.
  - Scan resumes from the held position when enable returns to 1.
- Outputs are registered with 1-cycle latency: outputs after edge n reflect the (idx, dwell_cnt) present before edge n.
- Lit condition for the current slot: enable & digit_en[idx] & (dwell_cnt < brightness) & ~suppressed(idx).
  - brightness max (DWELL-1) leaves one dark tick per slot (anti-ghost guard).
  - brightness=0 gives a permanently dark display; the scan still runs.
- Lit: anode = ~(1<<idx); seg = hex decode of digits[idx]; dp = ~dp_in[idx].
- Not lit: anode, seg and dp all 1s.
- Slot data capture:
  - seg/dp source value is captured only on the edge where dwell_cnt==0 (slot start).
  - Input changes mid-slot take effect at the next slot; no mid-slot glitch.
- Leading-zero suppression:
  - With lz_en=1, digit i>0 is suppressed if digits[j]==0 for all j>=i.
  - Digit 0 is never suppressed; value 0 therefore shows a single "0".
  - Suppression is evaluated on live inputs at slot start.
- Disabled or suppressed digits still consume their full slot; the refresh rate is fixed at DIGITS*DWELL cycles.
- Hex decode, active-low gfedcba:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- Never more than one anode low in any cycle.

Decomposition:
- Package seven_seg_pkg:
  - SEG_BLANK constant (7'h7F).
  - The 16-entry hex segment table as constants.
  - A function to compute DWELL from BRIGHT_W.
- Sub-module hex_to_seven_seg: purely combinational 4-bit value to 7-bit active-low segments. It is reused by other display blocks.
- The counters are written as registers in the top block, not built from the dff cell, to support parametrised width.

Test Plan:
All scenarios use DIGITS=4, BRIGHT_W=2.
- Reset: assert reset=0 mid-scan (idx=2) -> anode=4'hF, seg=7'h7F, dp=1 immediately. After release with enable=1, brightness=3, digit_en=F, digits=16'h1234: the first lit slot is digit 0 with anode=4'hE, seg=7'h19 ("4").
- Full scan: same inputs, run 16 cycles -> anode sequence E,E,E,F,D,D,D,F,B,B,B,F,7,7,7,F; seg patterns are 19,30,24,79.
- Brightness: set brightness=1 -> each slot shows 1 lit cycle then 3 blank cycles. Set brightness=0 -> anode stays F for 32 cycles while idx still wraps.
- Leading-zero suppression: lz_en=1, digits=16'h0050 -> digits 3 and 2 stay blank, digit 1 shows 7'h12, digit 0 shows 7'h40. digits=16'h0000 -> only digit 0 lit, showing 7'h40.
- Enable and dp: digit_en=4'b1010 -> anodes E and B never asserted. dp_in=4'b0100 -> dp=0 only while anode=B. Drop enable for 5 cycles -> outputs blank and idx holds; scan resumes at the same slot.
- Mid-slot change: change digits[3:0] from 4 to 8 at dwell_cnt=1 of slot 0 -> seg stays 19 for the rest of the slot and shows 00 at the next visit to slot 0.
